exec_cp0_unit: RTL and testbench

- Execution/system unit of the multi-cycle MIPS datapath. Three parts:
  - Combinational ALU with flag generation.
  - Combinational byte-access converter (BAC) between the datapath and 32-bit word data memory.
  - Clocked coprocessor-0 (CP0) that holds SR, Cause, EPC and PRId, and raises the hardware interrupt request.
- Sits between the A/B/ALUOut registers, data memory and the controller.

---
 rtl/exec_cp0_unit.sv | 197 +++++++++++++++++++
 tb/tb_exec_cp0_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_cp0_unit.sv
// Execution/system unit for the multi-cycle MIPS datapath.
// Combinational ALU with flag generation, a combinational byte-access
// converter between the datapath and word-wide data memory, and a clocked
// coprocessor-0 holding SR, Cause, EPC and PRId with interrupt request logic.
module exec_cp0_unit #(
    parameter int          DEV_CNT = 6,
    parameter logic [31:0] PRID    = 32'h0000_2019
) (
    input  logic               clk,
    input  logic               rst,
    // ALU
    input  logic [2:0]         alu_op,
    input  logic [31:0]        x,
    input  logic [31:0]        y,
    input  logic [4:0]         shamt,
    input  logic [31:0]        flag,
    output logic [31:0]        alu_out,
    output logic [31:0]        nflag,
    // Byte-access converter
    input  logic               bac_op,
    input  logic [31:0]        ain,
    input  logic [31:0]        din1,
    input  logic [31:0]        din2,
    output logic [31:0]        aout,
    output logic [31:0]        dout1,
    output logic [31:0]        dout2,
    // CP0
    input  logic [29:0]        pc,
    input  logic [31:0]        cp0_din,
    input  logic [DEV_CNT-1:0] hwint,
    input  logic [1:0]         sel,
    input  logic               cp0_wen,
    input  logic               exl_set,
    input  logic               exl_clr,
    output logic               int_req,
    output logic [29:0]        epc,
    output logic [31:0]        cp0_dout
);

    typedef enum logic [2:0] {
        OP_ADDU = 3'b000,
        OP_SUBU = 3'b001,
        OP_OR   = 3'b010,
        OP_ADD  = 3'b011,
        OP_SLT  = 3'b100,
        OP_LUI  = 3'b101,
        OP_SLL  = 3'b110,
        OP_AND  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SEL_SR    = 2'd0,
        SEL_CAUSE = 2'd1,
        SEL_EPC   = 2'd2,
        SEL_PRID  = 2'd3
    } cp0_sel_e;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    alu_op_e     w_op;
    logic [31:0] w_sum;
    logic        w_ovf;

    assign w_op  = alu_op_e'(alu_op);
    assign w_sum = x + y;
    // Signed overflow: operands share a sign that the sum does not.
    assign w_ovf = (x[31] == y[31]) && (w_sum[31] != x[31]);

    // Select the ALU result for the current operation.
    always_comb begin
        // NOTE: default first so every path assigns alu_out and no latch is inferred.
        alu_out = w_sum;
        case (w_op)
            OP_ADDU: alu_out = w_sum;
            OP_SUBU: alu_out = x - y;
            OP_OR:   alu_out = x | y;
            OP_ADD:  alu_out = w_sum;
            OP_SLT:  alu_out = {31'b0, ($signed(x) < $signed(y))};
            OP_LUI:  alu_out = {y[15:0], 16'h0000};
            OP_SLL:  alu_out = y << shamt;
            OP_AND:  alu_out = x & y;
            default: alu_out = w_sum;
        endcase
    end

    // Overflow bit only changes on ADD; bit 0 is the branch equality test.
    // The incoming flag[0] is always replaced, so it is tied off here.
    logic w_unused_flag0;
    assign w_unused_flag0 = flag[0];
    assign nflag = {flag[31:2], (w_op == OP_ADD) ? w_ovf : flag[1], (x == y)};

    // ------------------------------------------------------------------
    // Byte-access converter
    // ------------------------------------------------------------------
    logic [31:0] w_lane_shift;
    logic [7:0]  w_rd_byte;
    logic [31:0] w_merge;

    assign w_lane_shift = din2 >> {ain[1:0], 3'b000};
    assign w_rd_byte    = w_lane_shift[7:0];

    // Read-modify-write merge of the store byte into the addressed lane.
    always_comb begin
        w_merge = din2;
        case (ain[1:0])
            2'd0: w_merge = {din2[31:8], din1[7:0]};
            2'd1: w_merge = {din2[31:16], din1[7:0], din2[7:0]};
            2'd2: w_merge = {din2[31:24], din1[7:0], din2[15:0]};
            2'd3: w_merge = {din1[7:0], din2[23:0]};
            default: w_merge = din2;
        endcase
    end

    // Word mode passes through; byte mode word-aligns and converts data.
    always_comb begin
        aout  = ain;
        dout1 = din1;
        dout2 = din2;
        if (bac_op) begin
            aout  = {ain[31:2], 2'b00};
            dout1 = w_merge;
            dout2 = {{24{w_rd_byte[7]}}, w_rd_byte};
        end
    end

    // ------------------------------------------------------------------
    // CP0
    // ------------------------------------------------------------------
    logic [DEV_CNT-1:0] r_im;
    logic [DEV_CNT-1:0] r_ip;
    logic               r_exl;
    logic               r_ie;
    logic [29:0]        r_epc;

    logic w_sr_wr;
    logic w_epc_wr;

    assign w_sr_wr  = cp0_wen && (cp0_sel_e'(sel) == SEL_SR);
    assign w_epc_wr = cp0_wen && (cp0_sel_e'(sel) == SEL_EPC);

    // CP0 state: IP samples hwint every edge; EXL/EPC honour
    // exl_set > register write > exl_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all registered state avoid ordering races between always blocks.
            r_im  <= '0;
            r_ip  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_epc <= '0;
        end else begin
            r_ip <= hwint;
            if (w_sr_wr) begin
                r_im <= cp0_din[10 +: DEV_CNT];
                r_ie <= cp0_din[0];
            end
            if (exl_set) begin
                r_exl <= 1'b1;
                r_epc <= pc;
            end else begin
                if (w_sr_wr)
                    r_exl <= cp0_din[1];
                else if (exl_clr)
                    r_exl <= 1'b0;
                if (w_epc_wr)
                    r_epc <= cp0_din[31:2];
            end
        end
    end

    logic [5:0]  w_im6;
    logic [5:0]  w_ip6;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_im6   = 6'(r_im);
    assign w_ip6   = 6'(r_ip);
    assign w_sr    = {16'h0000, w_im6, 8'h00, r_exl, r_ie};
    assign w_cause = {16'h0000, w_ip6, 10'h000};

    assign int_req = (|(r_ip & r_im)) & r_ie & ~r_exl;
    assign epc     = r_epc;

    // Register read port selected by sel.
    always_comb begin
        cp0_dout = w_sr;
        case (cp0_sel_e'(sel))
            SEL_SR:    cp0_dout = w_sr;
            SEL_CAUSE: cp0_dout = w_cause;
            SEL_EPC:   cp0_dout = {r_epc, 2'b00};
            SEL_PRID:  cp0_dout = PRID;
            default:   cp0_dout = w_sr;
        endcase
    end

endmodule

// File: tb/tb_exec_cp0_unit.sv
// Self-checking bench for exec_cp0_unit: a word-level reference model checked
// every negative edge, plus directed vectors with hand-computed literals.
module tb_exec_cp0_unit;

    localparam logic [31:0] PRID = 32'h0000_2019;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_op;
    logic [31:0] x, y, flag;
    logic [4:0]  shamt;
    logic [31:0] alu_out, nflag;
    logic        bac_op;
    logic [31:0] ain, din1, din2, aout, dout1, dout2;
    logic [29:0] pc;
    logic [31:0] cp0_din;
    logic [5:0]  hwint;
    logic [1:0]  sel;
    logic        cp0_wen, exl_set, exl_clr;
    logic        int_req;
    logic [29:0] epc;
    logic [31:0] cp0_dout;

    int tests = 0;
    int fails = 0;

    exec_cp0_unit #(.DEV_CNT(6), .PRID(PRID)) dut (
        .clk(clk), .rst(rst),
        .alu_op(alu_op), .x(x), .y(y), .shamt(shamt), .flag(flag),
        .alu_out(alu_out), .nflag(nflag),
        .bac_op(bac_op), .ain(ain), .din1(din1), .din2(din2),
        .aout(aout), .dout1(dout1), .dout2(dout2),
        .pc(pc), .cp0_din(cp0_din), .hwint(hwint), .sel(sel),
        .cp0_wen(cp0_wen), .exl_set(exl_set), .exl_clr(exl_clr),
        .int_req(int_req), .epc(epc), .cp0_dout(cp0_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // CP0 kept as architectural 32-bit register images.
    logic [31:0] m_sr, m_cause, m_epc;

    always @(posedge clk or posedge rst) begin
        logic [31:0] sr_n;
        if (rst) begin
            m_sr    <= 32'h0;
            m_cause <= 32'h0;
            m_epc   <= 32'h0;
        end else begin
            sr_n = m_sr;
            if (cp0_wen && sel == 2'd0) sr_n = cp0_din & 32'h0000_FC03;
            if (exl_set) sr_n = sr_n | 32'h2;
            else if (!(cp0_wen && sel == 2'd0) && exl_clr) sr_n = sr_n & ~32'h2;
            m_sr    <= sr_n;
            m_cause <= {16'h0, hwint, 10'h0};
            if (exl_set) m_epc <= {pc, 2'b00};
            else if (cp0_wen && sel == 2'd2) m_epc <= cp0_din & ~32'h3;
        end
    end

    function automatic logic [63:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh,
                                            input logic [31:0] f);
        logic [31:0] r, nf;
        longint s;
        r  = 32'h0;
        nf = f;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a | b;
            3'd3: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = s[31:0];
                nf[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: r = b << 16;
            3'd6: r = b << sh;
            default: r = a & b;
        endcase
        nf[0] = (a == b);
        return {r, nf};
    endfunction

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [63:0] ar;
        logic [31:0] sh8, bsel, mrg, exp_dout;
        logic        exp_int;
        ar = alu_ref(alu_op, x, y, shamt, flag);
        check("cmp_alu_out", alu_out, ar[63:32]);
        check("cmp_nflag", nflag, ar[31:0]);
        sh8  = 32'(ain[1:0]) * 8;
        bsel = (din2 >> sh8) & 32'hFF;
        mrg  = (din2 & ~(32'hFF << sh8)) | ((din1 & 32'hFF) << sh8);
        check("cmp_aout",  aout,  bac_op ? (ain & ~32'h3) : ain);
        check("cmp_dout1", dout1, bac_op ? mrg : din1);
        check("cmp_dout2", dout2, bac_op ? (bsel[7] ? (bsel | 32'hFFFF_FF00) : bsel) : din2);
        exp_int = ((m_sr[15:10] & m_cause[15:10]) != 0) && m_sr[0] && !m_sr[1];
        check("cmp_int_req", {31'b0, int_req}, {31'b0, exp_int});
        check("cmp_epc", {epc, 2'b00}, m_epc);
        case (sel)
            2'd0: exp_dout = m_sr;
            2'd1: exp_dout = m_cause;
            2'd2: exp_dout = m_epc;
            default: exp_dout = PRID;
        endcase
        check("cmp_cp0_dout", cp0_dout, exp_dout);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] s, input string name, input logic [31:0] exp);
        sel = s;
        #1;
        check(name, cp0_dout, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        alu_op = 3'd0; x = 0; y = 0; shamt = 0; flag = 0;
        bac_op = 0; ain = 0; din1 = 0; din2 = 0;
        pc = 0; cp0_din = 0; hwint = 0; sel = 0;
        cp0_wen = 0; exl_set = 0; exl_clr = 0;
        tick(); tick();
        // Reset state
        rd(2'd0, "rst_sr", 32'h0);
        rd(2'd1, "rst_cause", 32'h0);
        rd(2'd3, "rst_prid", PRID);
        check("rst_int_req", {31'b0, int_req}, 32'h0);
        check("rst_epc", {2'b00, epc}, 32'h0);
        rst = 1'b0;
        tick();

        // ALU
        alu_op = 3'b011; x = 32'h7FFF_FFFF; y = 32'h1; flag = 32'h0; #1;
        check("add_res", alu_out, 32'h8000_0000);
        check("add_nflag", nflag, 32'h0000_0002);
        alu_op = 3'b000; flag = 32'hA5A5_0000; #1;
        check("addu_res", alu_out, 32'h8000_0000);
        check("addu_nflag", nflag, 32'hA5A5_0000);
        flag = 32'hA5A5_0002; #1;
        check("addu_nflag_keep", nflag, 32'hA5A5_0002);
        alu_op = 3'b011; x = 32'h1; y = 32'h2; flag = 32'h2; #1;
        check("add_noovf_nflag", nflag, 32'h0000_0000);
        alu_op = 3'b001; x = 5; y = 5; flag = 0; #1;
        check("subu_res", alu_out, 32'h0);
        check("subu_nflag", nflag, 32'h1);
        alu_op = 3'b100; x = 32'hFFFF_FFFF; y = 1; #1;
        check("slt_res", alu_out, 32'h1);
        alu_op = 3'b101; y = 32'h0000_1234; #1;
        check("lui_res", alu_out, 32'h1234_0000);
        alu_op = 3'b110; y = 1; shamt = 31; #1;
        check("sll_res", alu_out, 32'h8000_0000);
        alu_op = 3'b010; x = 32'hF0F0_0000; y = 32'h0000_0F0F; #1;
        check("or_res", alu_out, 32'hF0F0_0F0F);
        alu_op = 3'b111; x = 32'hFF00_FF00; y = 32'h0F0F_0F0F; #1;
        check("and_res", alu_out, 32'h0F00_0F00);
        tick();

        // BAC
        bac_op = 1; ain = 32'h1003; din1 = 32'h0000_00AB; din2 = 32'h1122_3344; #1;
        check("bac_aout", aout, 32'h1000);
        check("bac_dout1_l3", dout1, 32'hAB22_3344);
        check("bac_dout2_l3", dout2, 32'h0000_0011);
        din2 = 32'h8000_0000; #1;
        check("bac_dout2_sext", dout2, 32'hFFFF_FF80);
        ain = 32'h1000; din2 = 32'h1122_3344; #1;
        check("bac_dout1_l0", dout1, 32'h1122_33AB);
        check("bac_dout2_l0", dout2, 32'h0000_0044);
        bac_op = 0; ain = 32'h1003; din1 = 32'hDEAD_BEEF; #1;
        check("bac_pass_aout", aout, 32'h1003);
        check("bac_pass_dout1", dout1, 32'hDEAD_BEEF);
        check("bac_pass_dout2", dout2, 32'h1122_3344);
        tick();

        // CP0 write / read
        cp0_wen = 1; sel = 0; cp0_din = 32'h0000_FC01; tick(); cp0_wen = 0;
        rd(2'd0, "sr_write", 32'h0000_FC01);
        cp0_wen = 1; sel = 2; cp0_din = 32'h0000_3004; tick(); cp0_wen = 0;
        check("epc_write", {2'b00, epc}, 32'h0000_0C01);
        rd(2'd2, "epc_read", 32'h0000_3004);
        rd(2'd3, "prid_read", PRID);
        cp0_wen = 1; sel = 1; cp0_din = 32'hFFFF_FFFF; tick();
        sel = 3; tick(); cp0_wen = 0;
        rd(2'd0, "sr_unchanged", 32'h0000_FC01);
        check("epc_unchanged", {2'b00, epc}, 32'h0000_0C01);

        // Interrupt
        hwint = 6'b000010; #1;
        check("int_not_yet", {31'b0, int_req}, 32'h0);
        tick();
        check("int_raised", {31'b0, int_req}, 32'h1);
        rd(2'd1, "cause_ip", 32'h0000_0800);
        exl_set = 1; pc = 30'h0C00; tick(); exl_set = 0;
        rd(2'd0, "sr_exl", 32'h0000_FC03);
        check("epc_exc", {2'b00, epc}, 32'h0000_0C00);
        check("int_masked", {31'b0, int_req}, 32'h0);
        exl_clr = 1; tick(); exl_clr = 0;
        check("int_after_eret", {31'b0, int_req}, 32'h1);

        // Priority
        exl_set = 1; exl_clr = 1; pc = 30'h0456; tick(); exl_set = 0; exl_clr = 0;
        rd(2'd0, "prio_set_clr", 32'h0000_FC03);
        exl_clr = 1; tick(); exl_clr = 0;
        exl_set = 1; cp0_wen = 1; sel = 2; cp0_din = 32'hFFFF_0000; pc = 30'h0123;
        tick(); exl_set = 0; cp0_wen = 0;
        check("prio_epc", {2'b00, epc}, 32'h0000_0123);
        exl_clr = 1; tick(); exl_clr = 0;
        exl_set = 1; cp0_wen = 1; sel = 0; cp0_din = 32'h0000_0400; pc = 30'h0200;
        tick(); exl_set = 0; cp0_wen = 0;
        rd(2'd0, "prio_sr_im", 32'h0000_0402);
        check("prio_sr_epc", {2'b00, epc}, 32'h0000_0200);

        // Asynchronous reset mid-cycle with EXL=1
        cp0_wen = 1; sel = 0; cp0_din = 32'h0000_FC03; tick(); cp0_wen = 0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_int_req", {31'b0, int_req}, 32'h0);
        check("arst_epc", {2'b00, epc}, 32'h0);
        rd(2'd0, "arst_sr", 32'h0);
        rd(2'd1, "arst_cause", 32'h0);
        tick();
        rst = 1'b0;
        hwint = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
